hwce_wl_scheduler: RTL and testbench
====================================

Name: hwce_wl_scheduler

Overview:
Job-level sequencer for the HWCE weight loader. Per job it loads N weight sets from TCDM, one after another. For each set it computes the TCDM base address, pulses the loader start, waits for loader done, presents the loaded set to the convolution engine, and waits for the engine to release it. Sits between the HWCE register file/controller and the weight loader plus engine.

Parameters:
ADDR_WIDTH, 32, TCDM byte-address width.
NSET_WIDTH, 16, width of weight-set count and index.
TIMEOUT_CYCLES, 1024, loader-done watchdog limit (used only with the optional feature).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
job_start_i  in  1  one-cycle pulse; starts a job, sampled only in IDLE.
clear_i  in  1  synchronous abort; highest priority.
n_wsets_i  in  NSET_WIDTH  number of weight sets in the job; latched at job start.
base_addr_i  in  ADDR_WIDTH  TCDM address of set 0; latched at job start.
wset_stride_i  in  ADDR_WIDTH  byte stride between sets; latched at job start.
wl_start_o  out  1  one-cycle start pulse to the weight loader.
wl_base_addr_o  out  ADDR_WIDTH  base address for the current set.
wl_done_i  in  1  one-cycle done pulse from the weight loader.
wset_valid_o  out  1  current set is resident in loader storage.
wset_idx_o  out  NSET_WIDTH  index of the current set.
wset_release_i  in  1  engine has finished with the current set.
busy_o  out  1  high in every state except IDLE.
job_done_o  out  1  one-cycle pulse at job completion.
error_o  out  1  sticky watchdog error (optional feature only; otherwise tied to 0).

Behaviour:
- Reset values: state IDLE; all outputs 0; internal index and address registers 0.
- States: IDLE, START, WAIT_LOAD, VALID, NEXT, FINISH.
- IDLE:
  - If job_start_i=1, latch n_wsets, base and stride; set idx=0 and addr=base.
  - If n_wsets=0, go to FINISH; otherwise go to START.
- START:
  - wl_start_o=1 for exactly one cycle; wl_base_addr_o=addr.
  - Next state is WAIT_LOAD.
- WAIT_LOAD:
  - wl_base_addr_o is held stable for the whole wait.
  - On wl_done_i, go to VALID.
  - wl_done_i seen in any other state is ignored.
- VALID:
  - wset_valid_o=1 and wset_idx_o=idx; the set stays valid until wset_release_i.
  - On release: if idx==n_wsets-1, go to FINISH; otherwise go to NEXT.
  - wset_valid_o deasserts in the cycle after release is sampled.
- NEXT:
  - idx<=idx+1; addr<=addr+stride, computed modulo 2^ADDR_WIDTH (wraps silently).
  - Next state is START.
- FINISH:
  - job_done_o=1 for one cycle; next state is IDLE.
- Latency:
  - job_start to wl_start_o: 1 cycle.
  - wl_done to wset_valid_o: 1 cycle.
  - release to the next wl_start_o: 2 cycles.
- The loader is never restarted while a set is valid; its storage is single-buffered.
- job_start_i outside IDLE is ignored.
- wset_release_i outside VALID is ignored.
- clear_i in any state:
  - Next state is IDLE; all pulse and valid outputs drop next cycle.
  - No job_done_o is issued.
  - A loader transfer already in flight completes on its own; its done is ignored.
- Simultaneous events:
  - clear_i together with job_start_i: clear wins; the job is not started.
  - clear_i together with wset_release_i: clear wins.
- Asynchronous reset mid-job: immediate return to reset values.

Optional Feature:
- Macro: HWCE_WL_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_LOAD.
  - If TIMEOUT_CYCLES elapse with no wl_done_i: set error_o (sticky), go to FINISH, and pulse job_done_o.
  - error_o is cleared by clear_i or by the next accepted job_start_i.
- Undefined:
  - No counter is instantiated; error_o is constant 0; WAIT_LOAD waits indefinitely.

Decomposition:
- Shared package hwce_wl_pkg:
  - the state enum type;
  - default width constants (ADDR_WIDTH, NSET_WIDTH).
- One natural sub-module: hwce_wl_addr_gen, holding the idx/addr registers with load, step and clear controls.

Test Plan:
- Basic job: n_wsets=3, base=0x1000, stride=0x40; loader done 5 cycles after each start; engine releases 4 cycles after valid.
  - Expect wl_base_addr 0x1000, 0x1040, 0x1080.
  - Expect wset_idx 0, 1, 2.
  - Expect exactly 3 wl_start pulses and 1 job_done_o pulse.
- Empty job: n_wsets=0.
  - Expect no wl_start_o and job_done_o exactly 2 cycles after job_start_i.
- Address wrap: base=0xFFFFFFC0, stride=0x40, n_wsets=2.
  - Expect second wl_base_addr=0x00000000.
- Abort: clear_i in VALID of set 1 of 4.
  - Expect busy_o=0 and wset_valid_o=0 next cycle, with no job_done_o.
  - A later stray wl_done_i and wset_release_i cause no response.
- Ignored inputs: job_start_i in WAIT_LOAD, and wset_release_i in WAIT_LOAD.
  - Expect no state change; latched n_wsets and base are unchanged.
- With HWCE_WL_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, loader never signals done.
  - Expect error_o=1 and one job_done_o pulse 16 cycles into WAIT_LOAD.
  - Expect error_o=0 after the next job_start_i.

Source files
------------

// File: rtl/hwce_wl_pkg.sv
// -----------------------------------------------------------------------------
// hwce_wl_pkg
// Shared definitions for the HWCE weight-loader scheduler:
//   - default address / weight-set-count widths
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package hwce_wl_pkg;

    localparam int unsigned HWCE_WL_ADDR_WIDTH = 32;
    localparam int unsigned HWCE_WL_NSET_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_VALID     = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } wl_state_e;

endpackage

// File: rtl/hwce_wl_addr_gen.sv
// -----------------------------------------------------------------------------
// hwce_wl_addr_gen
// Holds the current weight-set index and TCDM base address for a job.
//   load_i  : idx <= 0, addr <= base_i, stride latched from stride_i
//   step_i  : idx <= idx + 1, addr <= addr + stride (wraps modulo 2^ADDR_WIDTH)
//   clear_i : synchronous clear of all registers (highest priority)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear_i, load_i, step_i  control strobes
//   base_i, stride_i      job base address and per-set byte stride
//   idx_o, addr_o         registered index and address
// -----------------------------------------------------------------------------
module hwce_wl_addr_gen
    import hwce_wl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = HWCE_WL_ADDR_WIDTH,
    parameter int unsigned NSET_WIDTH = HWCE_WL_NSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic [NSET_WIDTH-1:0] idx_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [NSET_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;

    // Next-value selection: clear, then load, then step, otherwise hold.
    always_comb begin
        idx_d    = idx_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        if (clear_i) begin
            idx_d    = {NSET_WIDTH{1'b0}};
            addr_d   = {ADDR_WIDTH{1'b0}};
            stride_d = {ADDR_WIDTH{1'b0}};
        end else if (load_i) begin
            idx_d    = {NSET_WIDTH{1'b0}};
            addr_d   = base_i;
            stride_d = stride_i;
        end else if (step_i) begin
            idx_d  = idx_q + {{(NSET_WIDTH-1){1'b0}}, 1'b1};
            // Unsigned add truncated to ADDR_WIDTH: wraps silently.
            addr_d = addr_q + stride_q;
        end else begin
            idx_d    = idx_q;
            addr_d   = addr_q;
            stride_d = stride_q;
        end
    end

    // Index / address / stride registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= {NSET_WIDTH{1'b0}};
            addr_q   <= {ADDR_WIDTH{1'b0}};
            stride_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/hwce_wl_scheduler.sv
// -----------------------------------------------------------------------------
// hwce_wl_scheduler
// Job-level sequencer for the HWCE weight loader. For each of n_wsets_i weight
// sets it pulses the loader start with the set's TCDM base address, waits for
// loader done, presents the set to the engine (wset_valid_o) and waits for the
// engine release before moving to the next set. job_done_o pulses at the end.
//
// Optional feature macro: HWCE_WL_SCHED_TIMEOUT_EN
//   defined   : loader-done watchdog of TIMEOUT_CYCLES cycles in WAIT_LOAD;
//               on expiry error_o is set (sticky) and the job finishes.
//   undefined : no watchdog, WAIT_LOAD waits forever, error_o tied to 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   job_start_i        job start pulse (accepted only in IDLE)
//   clear_i            synchronous abort, highest priority
//   n_wsets_i, base_addr_i, wset_stride_i   job parameters, latched at start
//   wl_start_o, wl_base_addr_o, wl_done_i   weight loader handshake
//   wset_valid_o, wset_idx_o, wset_release_i  engine handshake
//   busy_o, job_done_o, error_o             status
// -----------------------------------------------------------------------------
module hwce_wl_scheduler
    import hwce_wl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = HWCE_WL_ADDR_WIDTH,
    parameter int unsigned NSET_WIDTH     = HWCE_WL_NSET_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_start_i,
    input  logic                  clear_i,
    input  logic [NSET_WIDTH-1:0] n_wsets_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] wset_stride_i,
    output logic                  wl_start_o,
    output logic [ADDR_WIDTH-1:0] wl_base_addr_o,
    input  logic                  wl_done_i,
    output logic                  wset_valid_o,
    output logic [NSET_WIDTH-1:0] wset_idx_o,
    input  logic                  wset_release_i,
    output logic                  busy_o,
    output logic                  job_done_o,
    output logic                  error_o
);

    wl_state_e             state_q, state_d;
    logic                  wl_start_q, wl_start_d;
    logic                  wset_valid_q, wset_valid_d;
    logic                  busy_q, busy_d;
    logic                  job_done_q, job_done_d;
    logic [NSET_WIDTH-1:0] n_wsets_q, n_wsets_d;

    logic                  load_s;
    logic                  step_s;
    logic                  timeout_s;
    logic                  last_set_s;
    logic [NSET_WIDTH-1:0] idx_s;
    logic [ADDR_WIDTH-1:0] addr_s;

    hwce_wl_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NSET_WIDTH (NSET_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear_i),
        .load_i   (load_s),
        .step_i   (step_s),
        .base_i   (base_addr_i),
        .stride_i (wset_stride_i),
        .idx_o    (idx_s),
        .addr_o   (addr_s)
    );

    // Current set is the last one of the job.
    assign last_set_s = (idx_s == (n_wsets_q - {{(NSET_WIDTH-1){1'b0}}, 1'b1}));

`ifdef HWCE_WL_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;

    // Watchdog counter: counts cycles spent in WAIT_LOAD, restarts elsewhere.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_s = 1'b0;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (state_q == ST_WAIT_LOAD) begin
            timeout_s = (cnt_q == CNT_LAST);
            cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Sticky error: set on watchdog expiry, cleared by abort or a new job.
    always_comb begin
        error_d = error_q;
        if (clear_i) begin
            error_d = 1'b0;
        end else if (load_s) begin
            error_d = 1'b0;
        end else if (timeout_s && !wl_done_i) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign timeout_s = 1'b0;
    assign error_o   = 1'b0;
`endif

    // Sequencer next-state and next-output logic. Outputs are computed for the
    // state being entered so that they are registered and aligned with it.
    always_comb begin
        state_d      = state_q;
        wl_start_d   = 1'b0;
        wset_valid_d = 1'b0;
        job_done_d   = 1'b0;
        n_wsets_d    = n_wsets_q;
        load_s       = 1'b0;
        step_s       = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_start_i) begin
                        load_s    = 1'b1;
                        n_wsets_d = n_wsets_i;
                        if (n_wsets_i == {NSET_WIDTH{1'b0}}) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d    = ST_START;
                            wl_start_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT_LOAD;
                end
                ST_WAIT_LOAD: begin
                    if (wl_done_i) begin
                        state_d      = ST_VALID;
                        wset_valid_d = 1'b1;
                    end else if (timeout_s) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WAIT_LOAD;
                    end
                end
                ST_VALID: begin
                    if (wset_release_i) begin
                        state_d = last_set_s ? ST_FINISH : ST_NEXT;
                    end else begin
                        state_d      = ST_VALID;
                        wset_valid_d = 1'b1;
                    end
                end
                ST_NEXT: begin
                    step_s     = 1'b1;
                    state_d    = ST_START;
                    wl_start_d = 1'b1;
                end
                ST_FINISH: begin
                    // Pulse lands in the cycle after FINISH.
                    job_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wl_start_q   <= 1'b0;
            wset_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            n_wsets_q    <= {NSET_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            wl_start_q   <= wl_start_d;
            wset_valid_q <= wset_valid_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            n_wsets_q    <= n_wsets_d;
        end
    end

    assign wl_start_o     = wl_start_q;
    assign wl_base_addr_o = addr_s;
    assign wset_valid_o   = wset_valid_q;
    assign wset_idx_o     = idx_s;
    assign busy_o         = busy_q;
    assign job_done_o     = job_done_q;

endmodule

// File: tb/tb_hwce_wl_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hwce_wl_scheduler
// Self-checking bench for hwce_wl_scheduler. A table of jobs is run through a
// loader/engine responder; expected addresses and indices are queued when each
// job is issued and compared by a monitor when the DUT emits them. Abort,
// ignored inputs, asynchronous reset and (if enabled) the watchdog are
// exercised by hand-written sequences. Outputs are sampled on the falling
// edge, inputs are driven right after it.
// -----------------------------------------------------------------------------
module tb_hwce_wl_scheduler;

    localparam int AW = 32;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_start_i;
    logic          clear_i;
    logic [NW-1:0] n_wsets_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] wset_stride_i;
    logic          wl_start_o;
    logic [AW-1:0] wl_base_addr_o;
    logic          wl_done_i;
    logic          wset_valid_o;
    logic [NW-1:0] wset_idx_o;
    logic          wset_release_i;
    logic          busy_o;
    logic          job_done_o;
    logic          error_o;

    always #5 clk = ~clk;

    hwce_wl_scheduler #(
        .ADDR_WIDTH     (AW),
        .NSET_WIDTH     (NW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_start_i    (job_start_i),
        .clear_i        (clear_i),
        .n_wsets_i      (n_wsets_i),
        .base_addr_i    (base_addr_i),
        .wset_stride_i  (wset_stride_i),
        .wl_start_o     (wl_start_o),
        .wl_base_addr_o (wl_base_addr_o),
        .wl_done_i      (wl_done_i),
        .wset_valid_o   (wset_valid_o),
        .wset_idx_o     (wset_idx_o),
        .wset_release_i (wset_release_i),
        .busy_o         (busy_o),
        .job_done_o     (job_done_o),
        .error_o        (error_o)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] last_start_addr = '0;
    logic          valid_prev = 1'b0;
    logic [AW-1:0] exp_addr_q[$];
    logic [NW-1:0] exp_idx_q[$];

    typedef struct {
        logic [NW-1:0] n;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        int            exp_starts;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return wl_start_o;
            1:       return wset_valid_o;
            2:       return job_done_o;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for a DUT output; the final compare fails if the bound expires.
    task automatic wait_sig(input string name, input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sel(which)) break;
            tick();
        end
        check(name, 64'(sel(which)), 64'd1);
    endtask

    // Queue the expected addresses/indices, then pulse job_start for one cycle.
    task automatic start_job(input logic [NW-1:0] n, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride);
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(base + AW'(i) * stride);
            exp_idx_q.push_back(NW'(i));
        end
        n_wsets_i     = n;
        base_addr_i   = base;
        wset_stride_i = stride;
        job_start_i   = 1'b1;
        tick();
        job_start_i   = 1'b0;
    endtask

    // Loader responder: done after dly cycles, set valid one cycle later.
    task automatic load(input int dly);
        repeat (dly) tick();
        wl_done_i = 1'b1;
        tick();
        wl_done_i = 1'b0;
        check("valid_latency", 64'(wset_valid_o), 64'd1);
    endtask

    // Engine responder: release after dly cycles; next start two cycles later.
    task automatic release_set(input int dly, input logic last);
        repeat (dly) tick();
        wset_release_i = 1'b1;
        tick();
        wset_release_i = 1'b0;
        check("valid_drop", 64'(wset_valid_o), 64'd0);
        if (!last) begin
            tick();
            check("release_to_start", 64'(wl_start_o), 64'd1);
        end
    endtask

    task automatic run_job(input vec_t v);
        int s0;
        int d0;
        s0 = start_cnt;
        d0 = done_cnt;
        start_job(v.n, v.base, v.stride);
        if (v.n == '0) begin
            check("empty_no_start", 64'(wl_start_o), 64'd0);
            check("empty_done_early", 64'(job_done_o), 64'd0);
            tick();
            check("empty_done_2cyc", 64'(job_done_o), 64'd1);
        end else begin
            check("start_latency", 64'(wl_start_o), 64'd1);
            for (int i = 0; i < int'(v.n); i++) begin
                load(5);
                release_set(4, (i == int'(v.n) - 1));
            end
            wait_sig("job_done", 2, 10);
            check("last_addr", 64'(last_start_addr), 64'(v.exp_last));
        end
        tick();
        tick();
        check("busy_after_job", 64'(busy_o), 64'd0);
        check("start_count", 64'(start_cnt - s0), 64'(v.exp_starts));
        check("done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    // Monitor: scoreboard compare on every loader start and set presentation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (wl_start_o) begin
                    start_cnt++;
                    last_start_addr = wl_base_addr_o;
                    check("start_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                    if (exp_addr_q.size() > 0) begin
                        check("wl_base_addr", 64'(wl_base_addr_o), 64'(exp_addr_q.pop_front()));
                    end
                end
                if (wset_valid_o && !valid_prev) begin
                    check("valid_expected", 64'(exp_idx_q.size() > 0), 64'd1);
                    if (exp_idx_q.size() > 0) begin
                        check("wset_idx", 64'(wset_idx_o), 64'(exp_idx_q.pop_front()));
                    end
                end
                if (job_done_o) done_cnt++;
            end
            valid_prev = wset_valid_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s1;
        int d1;
        int cyc;

        vecs[0] = '{16'd3, 32'h0000_1000, 32'h0000_0040, 3, 32'h0000_1080};
        vecs[1] = '{16'd0, 32'h0000_4000, 32'h0000_0040, 0, 32'h0000_0000};
        vecs[2] = '{16'd2, 32'hFFFF_FFC0, 32'h0000_0040, 2, 32'h0000_0000};
        vecs[3] = '{16'd4, 32'h0000_2000, 32'h0000_0100, 4, 32'h0000_2300};
        vecs[4] = '{16'd1, 32'h0000_3000, 32'h0000_0010, 1, 32'h0000_3000};

        rst_n          = 1'b0;
        job_start_i    = 1'b0;
        clear_i        = 1'b0;
        n_wsets_i      = '0;
        base_addr_i    = '0;
        wset_stride_i  = '0;
        wl_done_i      = 1'b0;
        wset_release_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_wl_start", 64'(wl_start_o), 64'd0);
        check("rst_addr", 64'(wl_base_addr_o), 64'd0);
        check("rst_valid", 64'(wset_valid_o), 64'd0);
        check("rst_idx", 64'(wset_idx_o), 64'd0);
        check("rst_job_done", 64'(job_done_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);

        // Table-driven jobs
        foreach (vecs[k]) run_job(vecs[k]);

        // Abort in VALID of set 1 of 4, with a simultaneous release
        start_job(16'd4, 32'h0000_5000, 32'h0000_0010);
        load(5);
        release_set(4, 1'b0);
        load(5);
        d1 = done_cnt;
        clear_i        = 1'b1;
        wset_release_i = 1'b1;
        tick();
        clear_i        = 1'b0;
        wset_release_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_valid", 64'(wset_valid_o), 64'd0);
        check("abort_no_done", 64'(job_done_o), 64'd0);
        exp_addr_q.delete();
        exp_idx_q.delete();
        s1 = start_cnt;
        wl_done_i = 1'b1;
        tick();
        wl_done_i = 1'b0;
        wset_release_i = 1'b1;
        tick();
        wset_release_i = 1'b0;
        repeat (3) tick();
        check("stray_busy", 64'(busy_o), 64'd0);
        check("stray_valid", 64'(wset_valid_o), 64'd0);
        check("stray_starts", 64'(start_cnt - s1), 64'd0);
        check("stray_done", 64'(done_cnt - d1), 64'd0);

        // Clear together with job_start: job not started
        n_wsets_i   = 16'd2;
        job_start_i = 1'b1;
        clear_i     = 1'b1;
        tick();
        job_start_i = 1'b0;
        clear_i     = 1'b0;
        check("clear_vs_start_busy", 64'(busy_o), 64'd0);
        check("clear_vs_start_nostart", 64'(wl_start_o), 64'd0);

        // Ignored job_start / release while waiting for the loader
        s1 = start_cnt;
        start_job(16'd2, 32'h0000_6000, 32'h0000_0020);
        tick();
        n_wsets_i      = 16'd7;
        base_addr_i    = 32'hAAAA_0000;
        wset_stride_i  = 32'h0000_0001;
        job_start_i    = 1'b1;
        wset_release_i = 1'b1;
        tick();
        job_start_i    = 1'b0;
        wset_release_i = 1'b0;
        check("ign_busy", 64'(busy_o), 64'd1);
        check("ign_start", 64'(wl_start_o), 64'd0);
        check("ign_valid", 64'(wset_valid_o), 64'd0);
        check("ign_addr", 64'(wl_base_addr_o), 64'h6000);
        load(5);
        release_set(4, 1'b0);
        load(5);
        release_set(4, 1'b1);
        wait_sig("ign_job_done", 2, 10);
        tick();
        check("ign_starts", 64'(start_cnt - s1), 64'd2);

`ifdef HWCE_WL_SCHED_TIMEOUT_EN
        // Watchdog: loader never answers
        start_job(16'd1, 32'h0000_7000, 32'h0000_0000);
        cyc = 0;
        while (!job_done_o && cyc < 40) begin
            tick();
            cyc++;
        end
        // WAIT_LOAD is entered on the 2nd edge after start, FINISH 16 edges
        // later, and the pulse is visible one cycle after FINISH.
        check("to_done", 64'(job_done_o), 64'd1);
        check("to_cycles", 64'(cyc), 64'd18);
        check("to_error", 64'(error_o), 64'd1);
        exp_idx_q.delete();
        exp_addr_q.delete();
        repeat (2) tick();
        check("to_error_sticky", 64'(error_o), 64'd1);
        start_job(16'd0, 32'h0000_0000, 32'h0000_0000);
        check("to_error_cleared", 64'(error_o), 64'd0);
        tick();
        tick();
`else
        cyc = 0;
        check("error_tied_low", 64'(error_o + 1'(cyc)), 64'd0);
`endif

        // Asynchronous reset mid-job
        start_job(16'd3, 32'h0000_8000, 32'h0000_0008);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_addr", 64'(wl_base_addr_o), 64'd0);
        check("arst_idx", 64'(wset_idx_o), 64'd0);
        check("arst_valid", 64'(wset_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_idx_q.delete();
        tick();
        check("arst_after_busy", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
